// File: rtl/complex_sweep_checker.sv
// Exhaustive 3-input sweep checker: steps x_out through all 8 vectors, waits
// SETTLE cycles per vector, compares z_in against the TT0/TT1/TT2 truth tables
// and accumulates a failure count, failure mask and lowest failing index.
module complex_sweep_checker #(
    parameter logic [7:0]  TT0    = 8'b00100011,
    parameter logic [7:0]  TT1    = 8'b00111001,
    parameter logic [7:0]  TT2    = 8'b01010101,
    parameter int unsigned SETTLE = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [2:0] x_out,
    input  logic [2:0] z_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [7:0] err_mask,
    output logic [2:0] first_err_idx,
    output logic       err_pulse
);

    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned ERR_W = 4;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(7);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic [2:0]         expected_c;
    logic               fail_c;
    logic [ERR_W-1:0]   err_cnt_nxt_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode, vector comparison and the combinational failure strobe
    always_comb begin
        next_state    = state;
        expected_c    = {TT2[idx], TT1[idx], TT0[idx]};
        fail_c        = (state == S_CHECK) && (z_in != expected_c);
        err_cnt_nxt_c = fail_c ? (err_cnt + ERR_W'(1)) : err_cnt;
        err_pulse     = fail_c;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == SETTLE_END) begin
                    next_state = S_CHECK;
                end
            end
            S_CHECK: begin
                next_state = (idx == LAST_IDX) ? S_DONE : S_WAIT;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Sweep datapath: vector index, settle counter and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx           <= '0;
            x_out         <= '0;
            cnt           <= '0;
            err_cnt       <= '0;
            err_mask      <= '0;
            first_err_idx <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx           <= '0;
                        x_out         <= '0;
                        cnt           <= '0;
                        err_cnt       <= '0;
                        err_mask      <= '0;
                        first_err_idx <= '0;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                end
                S_CHECK: begin
                    if (fail_c) begin
                        err_cnt       <= err_cnt_nxt_c;
                        err_mask[idx] <= 1'b1;
                        if (err_cnt == '0) begin
                            first_err_idx <= idx;
                        end
                    end
                    if (idx != LAST_IDX) begin
                        idx   <= idx + IDX_W'(1);
                        x_out <= idx + IDX_W'(1);
                        cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags registered from the upcoming state so they track it exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
        end else begin
            busy <= (next_state == S_WAIT) || (next_state == S_CHECK);
            done <= (next_state == S_DONE);
            pass <= (next_state == S_DONE) && (err_cnt_nxt_c == '0);
        end
    end

endmodule

// File: tb/tb_complex_sweep_checker.sv
// Directed bench for complex_sweep_checker: behavioural stage-under-test model
// with selectable faults, latency/stepping checks and result checks.
module tb_complex_sweep_checker;

    localparam logic [7:0] TT0 = 8'b00100011;
    localparam logic [7:0] TT1 = 8'b00111001;
    localparam logic [7:0] TT2 = 8'b01010101;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] x_out;
    logic [2:0] z_in;
    logic       busy, done, pass, err_pulse;
    logic [3:0] err_cnt;
    logic [7:0] err_mask;
    logic [2:0] first_err_idx;

    logic       start1;
    logic [2:0] x_out1;
    logic [2:0] z_in1;
    logic       busy1, done1, pass1, err_pulse1;
    logic [3:0] err_cnt1;
    logic [7:0] err_mask1;
    logic [2:0] first_err_idx1;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 correct, 1 stuck at 000, 2 z[0] inverted at x=5
    int pulse_cnt = 0;
    logic [2:0] pulse_x = '0;

    complex_sweep_checker #(.TT0(TT0), .TT1(TT1), .TT2(TT2), .SETTLE(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_out(x_out), .z_in(z_in),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .err_mask(err_mask), .first_err_idx(first_err_idx), .err_pulse(err_pulse)
    );

    complex_sweep_checker #(.TT0(TT0), .TT1(TT1), .TT2(TT2), .SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .x_out(x_out1), .z_in(z_in1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
        .err_mask(err_mask1), .first_err_idx(first_err_idx1), .err_pulse(err_pulse1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] model(input logic [2:0] x, input int m);
        logic [2:0] z;
        z = {TT2[x], TT1[x], TT0[x]};
        if (m == 1) z = 3'b000;
        if (m == 2 && x == 3'd5) z[0] = ~z[0];
        return z;
    endfunction

    always_comb z_in  = model(x_out, mode);
    always_comb z_in1 = model(x_out1, 0);

    always @(negedge clk) begin
        if (err_pulse) begin
            pulse_cnt++;
            pulse_x = x_out;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start a sweep (edge 0) and follow it for 56 edges; rp>0 re-pulses start after that edge
    task automatic sweep(input int rp);
        int xe;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_done", 32'(done), 32'd0);
        chk("accept_errcnt", 32'(err_cnt), 32'd0);
        chk("accept_mask", 32'(err_mask), 32'd0);
        chk("accept_x", 32'(x_out), 32'd0);
        for (int e = 1; e <= 56; e++) begin
            @(posedge clk); #1;
            start = (e == rp);
            xe = (e / 7 > 7) ? 7 : e / 7;
            chk("x_step", 32'(x_out), 32'(xe));
            chk("done_lat", 32'(done), (e == 56) ? 32'd1 : 32'd0);
            chk("busy_lat", 32'(busy), (e == 56) ? 32'd0 : 32'd1);
        end
        start = 1'b0;
    endtask

    initial begin
        int p0;
        rst_n  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        mode   = 0;
        repeat (2) @(negedge clk);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_errcnt", 32'(err_cnt), 32'd0);
        chk("rst_pulse", 32'(err_pulse), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Correct model
        p0 = pulse_cnt;
        sweep(0);
        chk("ok_errcnt", 32'(err_cnt), 32'd0);
        chk("ok_mask", 32'(err_mask), 32'h00);
        chk("ok_pass", 32'(pass), 32'd1);
        chk("ok_pulses", 32'(pulse_cnt - p0), 32'd0);

        // Stuck-at-zero response; also results hold in DONE
        mode = 1;
        p0 = pulse_cnt;
        sweep(0);
        repeat (3) @(posedge clk); #1;
        chk("stuck_errcnt", 32'(err_cnt), 32'd7);
        chk("stuck_mask", 32'(err_mask), 32'h7F);
        chk("stuck_first", 32'(first_err_idx), 32'd0);
        chk("stuck_pass", 32'(pass), 32'd0);
        chk("stuck_done", 32'(done), 32'd1);
        chk("stuck_pulses", 32'(pulse_cnt - p0), 32'd7);

        // Single-bit fault at x=5
        mode = 2;
        p0 = pulse_cnt;
        sweep(0);
        chk("f5_errcnt", 32'(err_cnt), 32'd1);
        chk("f5_mask", 32'(err_mask), 32'h20);
        chk("f5_first", 32'(first_err_idx), 32'd5);
        chk("f5_pass", 32'(pass), 32'd0);
        chk("f5_pulses", 32'(pulse_cnt - p0), 32'd1);
        chk("f5_pulse_x", 32'(pulse_x), 32'd5);

        // Asynchronous reset mid-sweep at x_out=3, start held through release
        mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (21) @(posedge clk); #1;
        chk("mid_x", 32'(x_out), 32'd3);
        chk("mid_errcnt", 32'(err_cnt), 32'd3);
        #3;
        rst_n = 1'b0;
        start = 1'b1;
        #1;
        chk("arst_x", 32'(x_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_errcnt", 32'(err_cnt), 32'd0);
        chk("arst_mask", 32'(err_mask), 32'd0);
        chk("arst_pass", 32'(pass), 32'd0);
        @(negedge clk);
        mode = 0;
        rst_n = 1'b1;
        p0 = pulse_cnt;
        sweep(0);
        chk("rerun_errcnt", 32'(err_cnt), 32'd0);
        chk("rerun_pass", 32'(pass), 32'd1);

        // Re-pulse while busy on a failing sweep, then restart from DONE
        mode = 1;
        sweep(20);
        chk("rp_errcnt", 32'(err_cnt), 32'd7);
        chk("rp_first", 32'(first_err_idx), 32'd0);
        mode = 0;
        sweep(0);
        chk("rp2_errcnt", 32'(err_cnt), 32'd0);
        chk("rp2_mask", 32'(err_mask), 32'd0);
        chk("rp2_pass", 32'(pass), 32'd1);

        // SETTLE=1 instance: done at edge 16
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (15) @(posedge clk); #1;
        chk("s1_done15", 32'(done1), 32'd0);
        chk("s1_x15", 32'(x_out1), 32'd7);
        @(posedge clk); #1;
        chk("s1_done16", 32'(done1), 32'd1);
        chk("s1_pass", 32'(pass1), 32'd1);
        chk("s1_errcnt", 32'(err_cnt1), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
